wave_reader: RTL and testbench

WAVE_READER -- requirements
Module: wave_reader

---
 rtl/wave_reader.sv | 112 +++++++++++
 tb/tb_wave_reader.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_reader.sv
// wave_reader: phase-accumulator wavetable player. Reads a 16-entry sample
// memory through a registered address and presents samples over valid/ready.
module wave_reader (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  step,
    output logic [3:0]  address,
    input  logic [11:0] sample,
    output logic [11:0] dac_data,
    output logic        dac_valid,
    input  logic        dac_ready,
    output logic        wrap
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        PRESENT
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;
    logic [11:0] r_phase;
    logic [11:0] w_phase_nx;
    logic [11:0] r_dac_data;
    logic [11:0] w_dac_data_nx;
    logic        r_dac_valid;
    logic        w_dac_valid_nx;
    logic        r_wrap;
    logic        w_wrap_nx;
    logic [12:0] w_sum;

    // Carry out of the accumulator add doubles as the wrap indication.
    assign w_sum = {1'b0, r_phase} + {5'd0, step};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_phase     <= '0;
            r_dac_data  <= '0;
            r_dac_valid <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_phase     <= w_phase_nx;
            r_dac_data  <= w_dac_data_nx;
            r_dac_valid <= w_dac_valid_nx;
            r_wrap      <= w_wrap_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_phase_nx     = r_phase;
        w_dac_data_nx  = r_dac_data;
        w_dac_valid_nx = r_dac_valid;
        w_wrap_nx      = 1'b0;
        case (r_state)
            IDLE: begin
                w_phase_nx     = '0;
                w_dac_valid_nx = 1'b0;
                if (en) begin
                    w_state_nx = SETTLE;
                end
            end
            SETTLE: begin
                if (en) begin
                    w_state_nx = CAPTURE;
                end else begin
                    w_state_nx = IDLE;
                    w_phase_nx = '0;
                end
            end
            CAPTURE: begin
                if (en) begin
                    w_dac_data_nx  = sample;
                    w_dac_valid_nx = 1'b1;
                    w_state_nx     = PRESENT;
                end else begin
                    w_dac_valid_nx = 1'b0;
                    w_phase_nx     = '0;
                    w_state_nx     = IDLE;
                end
            end
            PRESENT: begin
                // Everything holds until the downstream handshake completes.
                if (dac_ready) begin
                    w_dac_valid_nx = 1'b0;
                    w_wrap_nx      = w_sum[12];
                    if (en) begin
                        w_phase_nx = w_sum[11:0];
                        w_state_nx = SETTLE;
                    end else begin
                        w_phase_nx = '0;
                        w_state_nx = IDLE;
                    end
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    assign address   = r_phase[11:8];
    assign dac_data  = r_dac_data;
    assign dac_valid = r_dac_valid;
    assign wrap      = r_wrap;

endmodule

// File: tb/tb_wave_reader.sv
// Self-checking bench for wave_reader: registered wavetable model plus a
// phase-model scoreboard checked on every accepted sample.
module tb_wave_reader;

    logic        clk;
    logic        rst;
    logic        en;
    logic [7:0]  step;
    logic [3:0]  address;
    logic [11:0] sample;
    logic [11:0] dac_data;
    logic        dac_valid;
    logic        dac_ready;
    logic        wrap;

    logic [11:0] mem_q = '0;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_xfer   = 0;
    int          n_wrap   = 0;

    logic [11:0] exp_q[$];
    logic [11:0] obs_q[$];
    logic [11:0] m_phase = '0;
    logic        pend_wrap = 1'b0;
    logic [12:0] m_sum;

    wave_reader dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .step      (step),
        .address   (address),
        .sample    (sample),
        .dac_data  (dac_data),
        .dac_valid (dac_valid),
        .dac_ready (dac_ready),
        .wrap      (wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) mem_q <= {address, 8'h5A};
    assign sample = mem_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: inputs only change just after a rising edge, so what is
    // seen here is exactly what the DUT samples on the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            pend_wrap = 1'b0;
            m_phase   = '0;
        end else begin
            check("wrap", wrap, pend_wrap);
            if (wrap) n_wrap++;
            pend_wrap = 1'b0;
            if (dac_valid && dac_ready) begin
                if (exp_q.size() == 0) check("sb_underflow", 1, 0);
                else check("data", dac_data, exp_q.pop_front());
                check("addr", address, m_phase[11:8]);
                obs_q.push_back(dac_data);
                n_xfer++;
                m_sum     = {1'b0, m_phase} + {5'd0, step};
                pend_wrap = m_sum[12];
                if (en) begin
                    m_phase = m_sum[11:0];
                    exp_q.push_back({m_phase[11:8], 8'h5A});
                end else begin
                    m_phase = '0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        m_phase = '0;
        exp_q.delete();
        exp_q.push_back(12'h05A);
        en = 1'b1;
    endtask

    task automatic stop_run(input string tag);
        en = 1'b0;
        tick();
        check({tag, "_addr"}, address, 4'd0);
        check({tag, "_valid"}, dac_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (dac_valid) check({tag, "_stays_idle"}, dac_valid, 1'b0);
        end
        exp_q.delete();
    endtask

    task automatic wait_valid(input string tag, output int lat);
        lat = 0;
        while (!dac_valid && lat < 50) begin
            tick();
            lat++;
        end
        check({tag, "_seen"}, dac_valid, 1'b1);
    endtask

    task automatic wait_xfers(input int n, input string tag, output int cyc);
        int target;
        target = n_xfer + n;
        cyc = 0;
        while (n_xfer < target && cyc < 400) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check({tag, "_reached"}, n_xfer, target);
        tick();
    endtask

    task automatic pulse_ready();
        dac_ready = 1'b1;
        tick();
        dac_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int cyc;
        int x0;
        logic ok;

        rst = 1'b1;
        en = 1'b0;
        step = 8'h00;
        dac_ready = 1'b0;
        #2;
        check("rst_addr", address, 4'd0);
        check("rst_data", dac_data, 12'h000);
        check("rst_valid", dac_valid, 1'b0);
        check("rst_wrap", wrap, 1'b0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Basic playback with step 0x40 and ready held high.
        step = 8'h40;
        dac_ready = 1'b1;
        obs_q.delete();
        start_run();
        wait_valid("t028_first", lat);
        check("t028_latency", lat, 3);
        wait_xfers(8, "t028", cyc);
        check("t028_span", cyc, 22);
        check("t028_s3", obs_q[3], 12'h05A);
        check("t028_s4", obs_q[4], 12'h15A);
        check("t028_s7", obs_q[7], 12'h15A);
        check("t028_addr", address, 4'd2);
        stop_run("t028_stop");

        // Near-full step: address 0,0,1,2,... and one wrap after sample 17.
        step = 8'hFF;
        n_wrap = 0;
        obs_q.delete();
        start_run();
        wait_xfers(16, "t029a", cyc);
        check("t029_no_early_wrap", n_wrap, 0);
        wait_xfers(1, "t029b", cyc);
        check("t029_wrap_pulse", wrap, 1'b1);
        check("t029_s1", obs_q[1], 12'h05A);
        check("t029_s2", obs_q[2], 12'h15A);
        check("t029_s16", obs_q[16], 12'hF5A);
        tick();
        check("t029_wrap_once", wrap, 1'b0);
        stop_run("t029_stop");

        // Zero step: same address forever, no wrap.
        step = 8'h00;
        n_wrap = 0;
        start_run();
        wait_xfers(5, "t021", cyc);
        check("t021_addr", address, 4'd0);
        check("t021_nowrap", n_wrap, 0);
        stop_run("t021_stop");

        // Back-pressure, step change under back-pressure, en drop in PRESENT.
        step = 8'h10;
        dac_ready = 1'b0;
        start_run();
        wait_valid("t030_first", lat);
        check("t030_latency", lat, 3);
        check("t030_data", dac_data, 12'h05A);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) step = 8'hFF;
            if (i == 5) en = 1'b0;
            if (i == 7) begin
                en = 1'b1;
                step = 8'h10;
            end
            tick();
            if (!dac_valid || dac_data != 12'h05A || address != 4'd0) ok = 1'b0;
        end
        check("t030_frozen", ok, 1'b1);
        x0 = n_xfer;
        pulse_ready();
        check("t030_one_xfer", n_xfer, x0 + 1);
        repeat (6) tick();
        check("t030_still_one", n_xfer, x0 + 1);
        check("t030_waiting", dac_valid, 1'b1);

        step = 8'h80;
        repeat (2) tick();
        pulse_ready();
        check("t033_addr_a", address, 4'd0);
        step = 8'hF0;
        tick();
        step = 8'h80;
        wait_valid("t033_v", lat);
        pulse_ready();
        check("t033_addr_b", address, 4'd1);
        wait_valid("t031_v", lat);
        check("t031_data", dac_data, 12'h15A);
        en = 1'b0;
        repeat (3) tick();
        check("t031_hold_valid", dac_valid, 1'b1);
        check("t031_hold_data", dac_data, 12'h15A);
        pulse_ready();
        check("t031_idle_valid", dac_valid, 1'b0);
        check("t031_idle_addr", address, 4'd0);
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (dac_valid) ok = 1'b0;
        end
        check("t031_no_valid", ok, 1'b1);
        check("sb_drain", exp_q.size(), 0);

        // en dropped in SETTLE with a non-zero phase.
        step = 8'h80;
        dac_ready = 1'b1;
        start_run();
        wait_xfers(2, "t031s", cyc);
        check("t031s_addr_before", address, 4'd1);
        stop_run("t031s_stop");

        // Asynchronous reset between edges with a pending sample.
        step = 8'h40;
        start_run();
        wait_xfers(6, "t032", cyc);
        dac_ready = 1'b0;
        wait_valid("t032_v", lat);
        check("t032_data_before", dac_data, 12'h15A);
        #2;
        rst = 1'b1;
        #1;
        check("t032_valid", dac_valid, 1'b0);
        check("t032_data", dac_data, 12'h000);
        check("t032_addr", address, 4'd0);
        check("t032_wrap", wrap, 1'b0);
        en = 1'b0;
        tick();
        rst = 1'b0;
        exp_q.delete();
        repeat (2) tick();
        check("t032_idle", dac_valid, 1'b0);
        dac_ready = 1'b1;
        obs_q.delete();
        start_run();
        wait_valid("t032_restart", lat);
        check("t032_latency", lat, 3);
        check("t032_restart_data", dac_data, 12'h05A);
        check("t032_restart_addr", address, 4'd0);
        wait_xfers(1, "t032r", cyc);
        stop_run("t032_stop");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
